// File: rtl/req_latch.sv
// Latches asynchronous request lines into a pending vector for a priority encoder.
// Each line has a 2-flop synchronizer, rising-edge detect, sticky overflow and post-ack blanking.
module req_latch #(
    parameter int HOLDOFF = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_in,
    input  logic [3:0] mask,
    input  logic       ack,
    input  logic [1:0] ack_id,
    output logic [3:0] pend,
    output logic       irq,
    output logic [3:0] overflow
);

    localparam logic [3:0] HOLD_LD = 4'(HOLDOFF);

    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] r_prev;
    logic [3:0] r_pend;
    logic [3:0] r_ovf;
    logic       r_irq;
    logic [3:0] r_hold [4];

    logic [3:0] w_event;
    logic [3:0] w_evt_ok;
    logic [3:0] w_ack_ok;
    logic [3:0] w_pend_nxt;
    logic [3:0] w_ovf_nxt;
    logic [3:0] w_hold_nxt [4];

    assign w_event = r_sync2 & ~r_prev;

    always_comb begin
        w_evt_ok   = '0;
        w_ack_ok   = '0;
        w_pend_nxt = r_pend;
        w_ovf_nxt  = r_ovf;
        for (int i = 0; i < 4; i++) begin
            w_hold_nxt[i] = (r_hold[i] != 4'd0) ? r_hold[i] - 4'd1 : 4'd0;
            w_evt_ok[i]   = w_event[i] & ~mask[i] & (r_hold[i] == 4'd0);
            w_ack_ok[i]   = ack & (ack_id == 2'(i)) & r_pend[i];
            // A coincident new event replaces the acknowledged one, so no blanking.
            if (w_evt_ok[i] && w_ack_ok[i]) begin
                w_pend_nxt[i] = 1'b1;
                w_ovf_nxt[i]  = 1'b0;
            end else if (w_ack_ok[i]) begin
                w_pend_nxt[i] = 1'b0;
                w_ovf_nxt[i]  = 1'b0;
                w_hold_nxt[i] = HOLD_LD;
            end else if (w_evt_ok[i]) begin
                if (r_pend[i]) begin
                    w_ovf_nxt[i] = 1'b1;
                end
                w_pend_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_pend  <= '0;
            r_ovf   <= '0;
            r_irq   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            r_sync1 <= req_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_pend  <= w_pend_nxt;
            r_ovf   <= w_ovf_nxt;
            // irq tracks the registered pend value without an extra cycle.
            r_irq   <= |w_pend_nxt;
            for (int i = 0; i < 4; i++) begin
                r_hold[i] <= w_hold_nxt[i];
            end
        end
    end

    assign pend     = r_pend;
    assign overflow = r_ovf;
    assign irq      = r_irq;

endmodule

// File: tb/tb_req_latch.sv
// Directed bench for req_latch; expectations are queued at stimulus time and
// popped once the DUT has had its latency to respond.
module tb_req_latch;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_in;
    logic [3:0] mask;
    logic       ack;
    logic [1:0] ack_id;
    logic [3:0] pend;
    logic       irq;
    logic [3:0] overflow;

    int n_total;
    int n_bad;

    typedef struct {
        string      tag;
        logic [3:0] pend;
        logic [3:0] ovf;
    } exp_t;

    exp_t sb_q[$];

    req_latch #(.HOLDOFF(4)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_in   (req_in),
        .mask     (mask),
        .ack      (ack),
        .ack_id   (ack_id),
        .pend     (pend),
        .irq      (irq),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input string tag, input logic [3:0] p, input logic [3:0] o);
        exp_t e;
        e.tag  = tag;
        e.pend = p;
        e.ovf  = o;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({e.tag, "_pend"}, 32'(pend), 32'(e.pend));
            chk({e.tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
            chk({e.tag, "_irq"}, 32'(irq), 32'(|e.pend));
        end
    endtask

    // Raise one line, let the 3-edge latency elapse, check, then hold low long enough to re-arm.
    task automatic pulse(input int line, input string tag, input logic [3:0] p, input logic [3:0] o);
        req_in[line] = 1'b1;
        push(tag, p, o);
        tick(3);
        pop_check();
        req_in[line] = 1'b0;
        tick(3);
    endtask

    task automatic do_ack(input logic [1:0] id, input string tag, input logic [3:0] p, input logic [3:0] o);
        ack    = 1'b1;
        ack_id = id;
        push(tag, p, o);
        tick(1);
        ack    = 1'b0;
        pop_check();
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        req_in  = '0;
        mask    = '0;
        ack     = 1'b0;
        ack_id  = '0;
        tick(2);
        push("reset", 4'b0000, 4'b0000);
        pop_check();

        // Line held high through reset release: pend appears after the third edge.
        rst_n  = 1'b1;
        req_in = 4'b0100;
        push("rel_e1", 4'b0000, 4'b0000);
        push("rel_e2", 4'b0000, 4'b0000);
        push("rel_e3", 4'b0100, 4'b0000);
        tick(1); pop_check();
        tick(1); pop_check();
        tick(1); pop_check();
        tick(3);
        push("held_once", 4'b0100, 4'b0000);
        pop_check();

        // Ack then an early re-pulse lands inside the blanking window.
        req_in = 4'b0000;
        do_ack(2'd2, "ack2", 4'b0000, 4'b0000);
        pulse(2, "blanked", 4'b0000, 4'b0000);
        pulse(2, "after_blank", 4'b0100, 4'b0000);
        do_ack(2'd2, "ack2b", 4'b0000, 4'b0000);
        tick(5);

        pulse(1, "ln1_first", 4'b0010, 4'b0000);
        pulse(1, "ln1_ovf", 4'b0010, 4'b0010);
        do_ack(2'd1, "ack1", 4'b0000, 4'b0000);
        tick(5);

        mask = 4'b1000;
        pulse(3, "masked", 4'b0000, 4'b0000);
        mask = 4'b0000;
        pulse(3, "unmasked", 4'b1000, 4'b0000);
        do_ack(2'd3, "ack3", 4'b0000, 4'b0000);
        tick(5);

        // Ack of an idle line must not start blanking.
        do_ack(2'd0, "ack_idle", 4'b0000, 4'b0000);
        pulse(0, "no_blank", 4'b0001, 4'b0000);
        do_ack(2'd0, "ack0", 4'b0000, 4'b0000);
        tick(5);

        // Event and ack coincide on line 2 while overflow is set.
        pulse(2, "l2_a", 4'b0100, 4'b0000);
        pulse(2, "l2_b", 4'b0100, 4'b0100);
        req_in[2] = 1'b1;
        tick(2);
        do_ack(2'd2, "coinc", 4'b0100, 4'b0000);
        req_in[2] = 1'b0;
        tick(3);

        // Event on line 1 while line 2 is acked in the same cycle.
        req_in[1] = 1'b1;
        tick(2);
        do_ack(2'd2, "indep", 4'b0010, 4'b0000);
        req_in[1] = 1'b0;
        tick(3);

        // Build overflow and an active holdoff, then reset mid-sequence.
        pulse(1, "pre_rst_ovf", 4'b0010, 4'b0010);
        pulse(0, "pre_rst_l0", 4'b0011, 4'b0010);
        do_ack(2'd0, "pre_rst_ack", 4'b0010, 4'b0010);
        rst_n = 1'b0;
        push("mid_reset", 4'b0000, 4'b0000);
        tick(1);
        pop_check();
        rst_n = 1'b1;
        pulse(0, "rst_cancel_blank", 4'b0001, 4'b0000);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/req_latch.md
REQ_LATCH -- requirements
Module: req_latch

Interface
REQ-001 Parameter: HOLDOFF, default 4, post-acknowledge blanking cycles per line; legal range 0..15; 0 disables blanking.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_in  input  4  asynchronous request lines; bit 3 has highest priority downstream.
REQ-005 mask  input  4  synchronous per-line mask; 1 = ignore new events on that line.
REQ-006 ack  input  1  one-cycle acknowledge strobe from the consumer.
REQ-007 ack_id  input  2  index of the line being acknowledged; valid only while ack=1.
REQ-008 pend  output  4  registered pending-request vector; drives the priority encoder input directly.
REQ-009 irq  output  1  registered; high whenever any pend bit is 1.
REQ-010 overflow  output  4  registered, sticky per line; an event arrived while that line was already pending.

Function
REQ-011 Each req_in bit SHALL pass through a 2-flop synchronizer (sync1, sync2) followed by a delay flop (prev); event[i] = sync2[i] & ~prev[i].
REQ-012 Latency: req_in[i] rising and sampled high at edge k SHALL set pend[i] at edge k+2, provided the line is not blocked; pend[i] is visible after edge k+2.
REQ-013 A line is blocked when mask[i]=1 or holdoff_cnt[i]!=0 in the cycle event[i] is high; a blocked event SHALL be discarded, changing neither pend nor overflow.
REQ-014 An unblocked event on a line with pend[i]=0 SHALL set pend[i]=1.
REQ-015 An unblocked event on a line with pend[i]=1 and no same-cycle ack of that line SHALL keep pend[i]=1 and set overflow[i]=1.
REQ-016 ack=1 with pend[ack_id]=1 SHALL clear pend[ack_id] and overflow[ack_id] at the next edge and load holdoff_cnt[ack_id]=HOLDOFF.
REQ-017 ack=1 with pend[ack_id]=0 SHALL be ignored: no state change, counter not reloaded.
REQ-018 Same-cycle unblocked event and valid ack on the same line: pend stays 1, overflow cleared, holdoff_cnt not loaded (the new event is now the pending one).
REQ-019 Events and acks on different lines in the same cycle SHALL be processed independently.
REQ-020 holdoff_cnt[i] (4 bits) SHALL decrement by 1 each cycle while nonzero and saturate at 0; blanking lasts exactly HOLDOFF cycles after the ack edge.
REQ-021 A line held high continuously SHALL generate exactly one event; a new event requires req_in to return low for at least 2 cycles and rise again.
REQ-022 mask SHALL NOT clear existing pend or overflow bits; it only gates new events.
REQ-023 irq SHALL equal the OR-reduction of the registered pend value in the same cycle (no extra latency).
REQ-024 pend SHALL never contain X when req_in is known; pend changes only on clk edges.

Reset
REQ-025 rst_n sampled low at a rising edge SHALL clear sync1, sync2, prev, pend, overflow, irq, and all holdoff counters to 0.
REQ-026 Reset SHALL take priority over any same-cycle event or ack.
REQ-027 A req_in bit held high through reset release SHALL produce one event, with pend set at the third edge after release.
REQ-028 Reset asserted mid-holdoff SHALL cancel blanking; the line accepts events immediately after release.

Verification
REQ-029 Reset, then req_in=4'b0100 held -> pend=4'b0000 after edges 1-2, pend=4'b0100 and irq=1 after edge 3; overflow=4'b0000.
REQ-030 pend=4'b0100, pulse ack with ack_id=2 -> pend=4'b0000, irq=0 next edge; re-pulse req_in[2] within 4 cycles -> discarded; after 4 cycles -> pend=4'b0100 after latency.
REQ-031 pend[1]=1, second rising pulse on req_in[1] -> overflow=4'b0010, pend=4'b0010; ack ack_id=1 -> overflow=4'b0000, pend=4'b0000.
REQ-032 mask=4'b1000, pulse req_in[3] -> pend=4'b0000; mask=0, pulse again -> pend=4'b1000.
REQ-033 ack with ack_id=0 while pend=4'b0000 -> no change, following req_in[0] pulse latches normally (no blanking).
REQ-034 Event on line 2 coincident with ack_id=2 while pend[2]=1 -> pend[2] stays 1, overflow[2]=0; rst_n low one edge mid-sequence -> all outputs 0 next cycle.
